// File: rtl/lampfpu_sqrt_rndpack_pkg.sv
// lampfpu_sqrt_rndpack_pkg
// Shared types and constants for the bfloat16 square-root round/pack stage.
// Provides the float field widths, the canonical special-result encodings,
// the special-case code carried between pipeline stages, and the operand
// classifier that resolves the special-case priority.
package lampfpu_sqrt_rndpack_pkg;

  localparam int LAMP_FLOAT_E_DW   = 8;
  localparam int LAMP_FLOAT_F_DW   = 7;
  localparam int LAMP_FLOAT_RND_DW = 3;
  localparam int LAMP_FLOAT_DW     = 1 + LAMP_FLOAT_E_DW + LAMP_FLOAT_F_DW;

  localparam logic [LAMP_FLOAT_DW-1:0] LAMP_FLOAT_QNAN = 16'h7FC0;
  localparam logic [LAMP_FLOAT_DW-1:0] LAMP_FLOAT_INF  = 16'h7F80;

  typedef enum logic [1:0] {
    SPC_NONE,
    SPC_QNAN,
    SPC_INF,
    SPC_ZERO
  } spc_e;

  // Square root of any NaN, or of a negative nonzero value, yields the
  // canonical quiet NaN. Only +Inf and +/-0 pass through as themselves.
  function automatic spc_e classifyOp(input logic sign, input logic isZero,
                                      input logic isInf, input logic isSnan,
                                      input logic isQnan);
    spc_e code;
    if (isSnan || isQnan)       code = SPC_QNAN;
    else if (sign && !isZero)   code = SPC_QNAN;
    else if (isInf)             code = SPC_INF;
    else if (isZero)            code = SPC_ZERO;
    else                        code = SPC_NONE;
    return code;
  endfunction

endpackage

// File: rtl/lampfpu_sqrt_rndpack_rne_round.sv
// lampfpu_rne_round
// Purely combinational round-to-nearest-even of a normalised significand.
// Ports:
//   f_i      {frac, G, R, S} unrounded fraction (hidden bit implied)
//   frac_o   rounded stored fraction (zero when the mantissa overflows)
//   carry_o  rounding overflowed 1.111..1 into 10.000..0; caller bumps exponent
module lampfpu_rne_round
  import lampfpu_sqrt_rndpack_pkg::*;
#(
  parameter int F_DW   = LAMP_FLOAT_F_DW,
  parameter int RND_DW = LAMP_FLOAT_RND_DW
) (
  input  logic [F_DW+RND_DW-1:0] f_i,
  output logic [F_DW-1:0]        frac_o,
  output logic                   carry_o
);

  logic [F_DW-1:0] frac;
  logic            guard;
  logic            rest;
  logic            inc;
  logic [F_DW+1:0] mant;

  assign frac  = f_i[F_DW+RND_DW-1:RND_DW];
  assign guard = f_i[RND_DW-1];
  assign rest  = |f_i[RND_DW-2:0];

  // Round up above half, or exactly at half when the LSB is odd (ties to even).
  assign inc  = guard & (rest | frac[0]);
  assign mant = {1'b0, 1'b1, frac} + {{(F_DW+1){1'b0}}, inc};

  assign carry_o = mant[F_DW+1];
  assign frac_o  = mant[F_DW-1:0];

endmodule

// File: rtl/lampfpu_sqrt_rndpack.sv
// lampfpu_sqrt_rndpack
// Round/pack stage behind the square-root core: rounds the unrounded root to
// nearest-even, resolves operand special cases and packs a bfloat16 result.
// Two register stages with a valid/ready handshake toward writeback.
// Optional feature macro: LAMP_FPU_SQRT_FLAGS_EN adds invalid_o / inexact_o.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   valid_i / ready_o   input beat handshake
//   signum_op_i         operand sign
//   e_i, f_i            biased exponent, {frac, G, R, S}
//   isZero/Inf/SNAN/QNAN_op_i  operand class flags
//   valid_o / ready_i   output handshake
//   res_o               packed {s, e, f}
//   invalid_o, inexact_o  exception flags (only with LAMP_FPU_SQRT_FLAGS_EN)
module lampfpu_sqrt_rndpack
  import lampfpu_sqrt_rndpack_pkg::*;
#(
  parameter int E_DW   = LAMP_FLOAT_E_DW,
  parameter int F_DW   = LAMP_FLOAT_F_DW,
  parameter int RND_DW = LAMP_FLOAT_RND_DW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic                   signum_op_i,
  input  logic [E_DW-1:0]        e_i,
  input  logic [F_DW+RND_DW-1:0] f_i,
  input  logic                   isZero_op_i,
  input  logic                   isInf_op_i,
  input  logic                   isSNAN_op_i,
  input  logic                   isQNAN_op_i,
`ifdef LAMP_FPU_SQRT_FLAGS_EN
  output logic                   invalid_o,
  output logic                   inexact_o,
`endif
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [E_DW+F_DW:0]     res_o
);

  localparam int RES_DW = 1 + E_DW + F_DW;

  logic                   advance;
  logic                   s1Load;

  logic                   s1Valid_q;
  spc_e                   s1Spc_q;
  logic                   s1Sign_q;
  logic [E_DW-1:0]        s1Exp_q;
  logic [F_DW+RND_DW-1:0] s1Frac_q;

  logic                   s2Valid_q;
  logic [RES_DW-1:0]      s2Res_q;
  logic [RES_DW-1:0]      s2Res_d;

  logic [F_DW-1:0]        rndFrac;
  logic                   rndCarry;
  logic [E_DW-1:0]        expInc;

  // Stage 2 drains when empty or popped; stage 1 refills when it is empty
  // or moving into stage 2. ready_o depends only on state and ready_i.
  assign advance = !s2Valid_q || ready_i;
  assign s1Load  = !s1Valid_q || advance;
  assign ready_o = s1Load;

  lampfpu_rne_round #(
    .F_DW   (F_DW),
    .RND_DW (RND_DW)
  ) u_round (
    .f_i     (s1Frac_q),
    .frac_o  (rndFrac),
    .carry_o (rndCarry)
  );

  assign expInc = s1Exp_q + {{(E_DW-1){1'b0}}, 1'b1};

  // Pack the result; a mantissa carry that pushes the exponent to all-ones
  // overflows to +Inf. Normal roots are never negative.
  always_comb begin
    s2Res_d = '0;
    case (s1Spc_q)
      SPC_QNAN: s2Res_d = LAMP_FLOAT_QNAN;
      SPC_INF:  s2Res_d = LAMP_FLOAT_INF;
      SPC_ZERO: s2Res_d = {s1Sign_q, {(RES_DW-1){1'b0}}};
      default: begin
        if (rndCarry) begin
          if (expInc == {E_DW{1'b1}}) s2Res_d = LAMP_FLOAT_INF;
          else                        s2Res_d = {1'b0, expInc, {F_DW{1'b0}}};
        end else begin
          s2Res_d = {1'b0, s1Exp_q, rndFrac};
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid_q <= 1'b0;
      s1Spc_q   <= SPC_NONE;
      s1Sign_q  <= 1'b0;
      s1Exp_q   <= '0;
      s1Frac_q  <= '0;
    end else if (s1Load) begin
      s1Valid_q <= valid_i;
      if (valid_i) begin
        s1Spc_q  <= classifyOp(signum_op_i, isZero_op_i, isInf_op_i,
                               isSNAN_op_i, isQNAN_op_i);
        s1Sign_q <= signum_op_i;
        s1Exp_q  <= e_i;
        s1Frac_q <= f_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2Valid_q <= 1'b0;
      s2Res_q   <= '0;
    end else if (advance) begin
      s2Valid_q <= s1Valid_q;
      if (s1Valid_q) s2Res_q <= s2Res_d;
    end
  end

  assign valid_o = s2Valid_q;
  assign res_o   = s2Res_q;

`ifdef LAMP_FPU_SQRT_FLAGS_EN
  logic s1Invalid_q;
  logic s2Invalid_q;
  logic s2Inexact_q;
  logic s2Inexact_d;

  // A quiet NaN input propagates without raising invalid.
  assign s2Inexact_d = (s1Spc_q == SPC_NONE) && (|s1Frac_q[RND_DW-1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1Invalid_q <= 1'b0;
      s2Invalid_q <= 1'b0;
      s2Inexact_q <= 1'b0;
    end else begin
      if (s1Load && valid_i)
        s1Invalid_q <= isSNAN_op_i ||
                       (signum_op_i && !isZero_op_i && !isQNAN_op_i);
      if (advance && s1Valid_q) begin
        s2Invalid_q <= s1Invalid_q;
        s2Inexact_q <= s2Inexact_d;
      end
    end
  end

  assign invalid_o = s2Invalid_q;
  assign inexact_o = s2Inexact_q;
`endif

endmodule

// File: tb/tb_lampfpu_sqrt_rndpack.sv
// tb_lampfpu_sqrt_rndpack
// Directed self-checking bench for the square-root round/pack stage.
// Inputs change 1ns after a rising edge; outputs are sampled either 1ns after
// a rising edge or on the falling edge, never on the active edge.
// Flag checks are included when LAMP_FPU_SQRT_FLAGS_EN is defined.
module tb_lampfpu_sqrt_rndpack;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic        ready_o;
  logic        signum_op_i;
  logic [7:0]  e_i;
  logic [9:0]  f_i;
  logic        isZero_op_i;
  logic        isInf_op_i;
  logic        isSNAN_op_i;
  logic        isQNAN_op_i;
  logic        invalid_o;
  logic        inexact_o;
  logic        valid_o;
  logic        ready_i;
  logic [15:0] res_o;

  int checkCount = 0;
  int passCount  = 0;

  lampfpu_sqrt_rndpack dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .signum_op_i (signum_op_i),
    .e_i         (e_i),
    .f_i         (f_i),
    .isZero_op_i (isZero_op_i),
    .isInf_op_i  (isInf_op_i),
    .isSNAN_op_i (isSNAN_op_i),
    .isQNAN_op_i (isQNAN_op_i),
`ifdef LAMP_FPU_SQRT_FLAGS_EN
    .invalid_o   (invalid_o),
    .inexact_o   (inexact_o),
`endif
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .res_o       (res_o)
  );

`ifndef LAMP_FPU_SQRT_FLAGS_EN
  assign invalid_o = 1'b0;
  assign inexact_o = 1'b0;
`endif

  // 10ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison funnels through here so the counts stay consistent.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  task automatic driveBeat(input logic sgn, input logic [7:0] e, input logic [9:0] f,
                           input logic zero, input logic inf, input logic snan,
                           input logic qnan);
    valid_i     = 1'b1;
    signum_op_i = sgn;
    e_i         = e;
    f_i         = f;
    isZero_op_i = zero;
    isInf_op_i  = inf;
    isSNAN_op_i = snan;
    isQNAN_op_i = qnan;
  endtask

  // Send one beat with ready_i high and check result, latency and flags.
  task automatic applyStimulus(input string tag, input logic sgn, input logic [7:0] e,
                               input logic [9:0] f, input logic zero, input logic inf,
                               input logic snan, input logic qnan,
                               input logic [15:0] expRes, input logic expInvalid,
                               input logic expInexact);
    int lat;
    @(posedge clk); #1;
    driveBeat(sgn, e, f, zero, inf, snan, qnan);
    @(negedge clk);
    checkOutput({tag, "_ready"}, 32'(ready_o), 32'd1);
    @(posedge clk); #1;
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'd2);
    checkOutput({tag, "_res"}, 32'(res_o), 32'(expRes));
`ifdef LAMP_FPU_SQRT_FLAGS_EN
    checkOutput({tag, "_invalid"}, 32'(invalid_o), 32'(expInvalid));
    checkOutput({tag, "_inexact"}, 32'(inexact_o), 32'(expInexact));
`else
    if (expInvalid && expInexact) lat = 0;
`endif
  endtask

  initial begin
    logic [15:0] popped[$];
    logic        accepted;

    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    signum_op_i = 1'b0; e_i = '0; f_i = '0;
    isZero_op_i = 1'b0; isInf_op_i = 1'b0; isSNAN_op_i = 1'b0; isQNAN_op_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_valid_o", 32'(valid_o), 32'd0);
    checkOutput("reset_res_o",   32'(res_o),   32'h0000);
    checkOutput("reset_ready_o", 32'(ready_o), 32'd1);
    rst = 1'b0;

    // Normal and rounding paths
    applyStimulus("exact",      1'b0, 8'd128, {7'b0000000, 3'b000}, 0,0,0,0, 16'h4000, 0, 0);
    applyStimulus("tie_odd",    1'b0, 8'd128, {7'b0000001, 3'b100}, 0,0,0,0, 16'h4002, 0, 1);
    applyStimulus("tie_even",   1'b0, 8'd128, {7'b0000000, 3'b100}, 0,0,0,0, 16'h4000, 0, 1);
    applyStimulus("below_half", 1'b0, 8'd126, {7'b1010101, 3'b011}, 0,0,0,0, 16'h3F55, 0, 1);
    applyStimulus("carry",      1'b0, 8'd127, {7'b1111111, 3'b110}, 0,0,0,0, 16'h4000, 0, 1);
    applyStimulus("carry_inf",  1'b0, 8'd254, {7'b1111111, 3'b110}, 0,0,0,0, 16'h7F80, 0, 1);

    // Special cases
    applyStimulus("neg_normal", 1'b1, 8'd128, 10'd0, 0,0,0,0, 16'h7FC0, 1, 0);
    applyStimulus("neg_zero",   1'b1, 8'd0,   10'd0, 1,0,0,0, 16'h8000, 0, 0);
    applyStimulus("pos_inf",    1'b0, 8'hFF,  10'd0, 0,1,0,0, 16'h7F80, 0, 0);
    applyStimulus("snan",       1'b0, 8'hFF,  10'h0A8, 0,0,1,0, 16'h7FC0, 1, 0);
    applyStimulus("qnan",       1'b0, 8'hFF,  10'h200, 0,0,0,1, 16'h7FC0, 0, 0);

    // Backpressure: three beats, consumer stalled for four cycles
    @(posedge clk); #1;
    ready_i = 1'b0;
    driveBeat(1'b0, 8'd128, {7'b0000001, 3'b000}, 0,0,0,0);
    @(negedge clk);
    checkOutput("bp_ready_a", 32'(ready_o), 32'd1);
    @(posedge clk); #1;
    driveBeat(1'b0, 8'd128, {7'b0000010, 3'b000}, 0,0,0,0);
    @(negedge clk);
    checkOutput("bp_ready_b", 32'(ready_o), 32'd1);
    @(posedge clk); #1;
    driveBeat(1'b0, 8'd128, {7'b0000011, 3'b000}, 0,0,0,0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("bp_stall_ready_%0d", i), 32'(ready_o), 32'd0);
      checkOutput($sformatf("bp_stall_valid_%0d", i), 32'(valid_o), 32'd1);
      checkOutput($sformatf("bp_stall_res_%0d", i),   32'(res_o),   32'h4001);
      @(posedge clk); #1;
    end
    ready_i  = 1'b1;
    accepted = 1'b0;
    for (int cyc = 0; cyc < 12 && popped.size() < 3; cyc++) begin
      @(negedge clk);
      if (valid_o) popped.push_back(res_o);
      if (valid_i && ready_o) accepted = 1'b1;
      @(posedge clk); #1;
      if (accepted) valid_i = 1'b0;
    end
    checkOutput("bp_pop_count", 32'(popped.size()), 32'd3);
    while (popped.size() < 3) popped.push_back(16'hDEAD);
    checkOutput("bp_pop_0", 32'(popped[0]), 32'h4001);
    checkOutput("bp_pop_1", 32'(popped[1]), 32'h4002);
    checkOutput("bp_pop_2", 32'(popped[2]), 32'h4003);
    @(negedge clk);
    checkOutput("bp_drained", 32'(valid_o), 32'd0);

    // Reset with both stages holding beats
    @(posedge clk); #1;
    ready_i = 1'b0;
    driveBeat(1'b0, 8'd130, 10'd0, 0,0,0,0);
    @(posedge clk); #1;
    driveBeat(1'b0, 8'd131, 10'd0, 0,0,0,0);
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(negedge clk);
    checkOutput("rst_pre_valid", 32'(valid_o), 32'd1);
    checkOutput("rst_pre_ready", 32'(ready_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rst_mid_valid", 32'(valid_o), 32'd0);
    checkOutput("rst_mid_res",   32'(res_o),   32'h0000);
    checkOutput("rst_mid_ready", 32'(ready_o), 32'd1);
    ready_i = 1'b1;
    applyStimulus("after_rst", 1'b0, 8'd128, 10'd0, 0,0,0,0, 16'h4000, 0, 0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("after_rst_no_dup", 32'(valid_o), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/lampfpu_sqrt_rndpack.md
Name: lampfpu_sqrt_rndpack

Overview:
- Stage directly downstream of the square-root core (lampFPU_sqrt).
- Takes the unrounded root (sign, biased exponent, 7-bit fraction plus guard/round/sticky) and the operand special-case flags.
- Applies round-to-nearest-even, resolves special cases and packs a 16-bit bfloat16 result.
- Two-stage pipeline with valid/ready handshake toward the FPU writeback.

Parameters:
- E_DW, 8, exponent width (matches LAMP_FLOAT_E_DW).
- F_DW, 7, stored fraction width (matches LAMP_FLOAT_F_DW).
- RND_DW, 3, extra rounding bits below the fraction LSB: guard, round, sticky.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- valid_i  in  1  input beat valid
- ready_o  out  1  block can accept a beat this cycle
- signum_op_i  in  1  original operand sign
- e_i  in  E_DW  biased result exponent from the sqrt stage
- f_i  in  F_DW+RND_DW  unrounded fraction {frac, G, R, S}
- isZero_op_i, isInf_op_i, isSNAN_op_i, isQNAN_op_i  in  1 each  operand class flags
- valid_o  out  1  result valid
- ready_i  in  1  consumer accepts the result
- res_o  out  1+E_DW+F_DW  packed {s, e, f}

Behaviour:
- Clocking and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: all valids 0, res_o 16'h0000, ready_o 1.
- Stage 1 register captures the inputs on a valid_i && ready_o handshake and computes in the same cycle:
  - special-case code, priority: SNAN > QNAN > (sign=1 and not zero) > +Inf > zero > normal;
  - rounding increment inc = G & (R | S | frac[0]).
- Stage 2 register captures:
  - mant = {1, frac} + inc (F_DW+2 bits);
  - on carry out: frac = 0 and e = e_i + 1; if that exponent reaches 8'hFF, the result is +Inf 0x7F80.
- Special results:
  - SNAN, QNAN, negative nonzero → canonical qNaN 0x7FC0.
  - +Inf → 0x7F80.
  - Zero → sign preserved: +0 gives 0x0000, −0 gives 0x8000.
  - Normal → {0, e, frac}; the sign is always 0.
- Latency is 2 cycles from input handshake to valid_o with ready_i=1. Throughput is 1 beat per cycle.
- Advance rule: advance = !s2_valid | ready_i.
  - Stage 2 loads stage 1 when advance holds.
  - Stage 1 loads the input when !s1_valid | advance.
  - ready_o = !s1_valid | advance (combinational from ready_i; no input-to-output path on data).
- While valid_o=1 && ready_i=0, res_o and flags stay stable. No beat is dropped or duplicated, and order is preserved.
- A simultaneous input handshake and output pop in one cycle moves both stages.
- Reset in the middle of operation flushes both stages; valid_o drops on the next edge and in-flight beats are discarded.
- valid_i with ready_o=0 is ignored; the upstream holds its beat.

Optional Feature:
- Macro: LAMP_FPU_SQRT_FLAGS_EN.
- Defined: adds outputs invalid_o and inexact_o, registered alongside res_o with the same valid/stall semantics.
  - invalid_o = 1 for SNAN or negative nonzero input.
  - inexact_o = (G|R|S) on the normal path.
- Undefined: these ports and their logic are absent; res_o behaviour is unchanged.

Decomposition:
- Add to lampFPU_pkg:
  - typedef for the special-case code (SPC_NONE, SPC_QNAN, SPC_INF, SPC_ZERO);
  - constants LAMP_FLOAT_QNAN (16'h7FC0) and LAMP_FLOAT_INF (16'h7F80);
  - LAMP_FLOAT_RND_DW = 3.
- One natural sub-module: lampfpu_rne_round, purely combinational; takes {frac, G, R, S} and returns the rounded mantissa and carry. It is reusable by the other FPU stages.

Test Plan:
- Normal exact case: e_i=128, f_i=0, ready_i=1 → res_o=0x4000 exactly 2 cycles later; inexact_o=0.
- Tie rounds to even:
  - f_i={7'b0000001, 3'b100} → frac 0000010;
  - f_i={7'b0000000, 3'b100} → frac 0000000 (unchanged).
- Mantissa carry: e_i=127, f_i={7'b1111111, 3'b110} → res_o=0x4000; with e_i=254 the same f_i gives 0x7F80.
- Special cases:
  - signum=1, nonzero normal → 0x7FC0, invalid_o=1;
  - −0 → 0x8000;
  - +Inf → 0x7F80;
  - SNAN → 0x7FC0, invalid_o=1.
- Backpressure: 3 back-to-back beats with ready_i held low for 4 cycles.
  - ready_o falls after 2 beats are accepted.
  - res_o is stable while stalled.
  - On release, all 3 results emerge in order with no loss.
- Reset mid-operation: rst is asserted with both stages full → valid_o=0 and res_o=0x0000 on the next edge; a new beat afterwards completes normally.
